// File: rtl/t_toggle_pkg.sv
// Shared types and defaults for the toggle decoder and its synchronizer.
package t_toggle_pkg;

    typedef enum logic {
        SETTLE = 1'b0,
        ARMED  = 1'b1
    } state_t;

    localparam int CNT_W_DEF      = 8;
    localparam int SETTLE_CYC_DEF = 4;
    localparam int SETTLE_W       = 8;

endpackage

// File: rtl/t_toggle_decoder_if.sv
// Event-count read/clear bus between the toggle decoder (master) and its consumer (slave).
interface t_toggle_decoder_if #(
    parameter int CNT_W = 8
);
    // Handshake: cnt_valid is high while evt_cnt != 0; a cycle with cnt_valid && cnt_ack
    // transfers evt_cnt and clears it (and ovf). cnt_ack with cnt_valid low is ignored.
    logic [CNT_W-1:0] evt_cnt;
    logic             cnt_valid;
    logic             cnt_ack;
    logic             ovf;

    modport master (
        output evt_cnt,
        output cnt_valid,
        output ovf,
        input  cnt_ack
    );

    modport slave (
        input  evt_cnt,
        input  cnt_valid,
        input  ovf,
        output cnt_ack
    );
endinterface

// File: rtl/t_toggle_sync.sv
// Two-flop synchronizer for a toggle line arriving from another clock domain.
module t_toggle_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/t_toggle_decoder.sv
// Toggle-to-pulse decoder with a settle phase and a saturating, ack-cleared event count.
// Define T_TOGGLE_DECODER_SYNC_EN to put a 2-flop synchronizer in front of the sampler.
module t_toggle_decoder
    import t_toggle_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tog_in,
    output logic                 pulse,
    output logic                 level,
    output logic                 armed,
    output state_t               state_dbg,
    t_toggle_decoder_if.master   cnt_bus
);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);

    logic s_in;

`ifdef T_TOGGLE_DECODER_SYNC_EN
    t_toggle_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (tog_in),
        .q   (s_in)
    );
`else
    assign s_in = tog_in;
`endif

    logic                s_q;
    logic                s_prev;
    logic                tog_edge;
    state_t              state;
    state_t              state_nxt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [SETTLE_W-1:0] settle_nxt;
    logic                pulse_nxt;
    logic [CNT_W-1:0]    evt_cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                cnt_valid;
    logic                ovf;
    logic                ovf_nxt;
    logic                inc;
    logic                ack;

    assign tog_edge = s_q ^ s_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q        <= 1'b0;
            s_prev     <= 1'b0;
            state      <= SETTLE;
            settle_cnt <= '0;
            pulse      <= 1'b0;
            evt_cnt    <= '0;
            cnt_valid  <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            s_q        <= s_in;
            s_prev     <= s_q;
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
            pulse      <= pulse_nxt;
            evt_cnt    <= cnt_nxt;
            cnt_valid  <= (cnt_nxt != '0);
            ovf        <= ovf_nxt;
        end
    end

    // The level present while settling becomes the reference; any edge restarts the wait.
    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        pulse_nxt  = 1'b0;
        case (state)
            SETTLE: begin
                if (tog_edge) begin
                    settle_nxt = '0;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = ARMED;
                end else begin
                    settle_nxt = settle_cnt + 1'b1;
                end
            end
            ARMED: begin
                pulse_nxt = tog_edge;
            end
            default: begin
                state_nxt = SETTLE;
            end
        endcase
    end

    // The event is counted from the pulse cycle, so an ack in that same cycle leaves count 1.
    assign inc = pulse;
    assign ack = cnt_bus.cnt_ack & cnt_valid;

    always_comb begin
        cnt_nxt = evt_cnt;
        ovf_nxt = ovf;
        if (ack) begin
            cnt_nxt = inc ? CNT_W'(1) : '0;
            ovf_nxt = 1'b0;
        end else if (inc) begin
            if (&evt_cnt) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = evt_cnt + 1'b1;
            end
        end
    end

    assign level             = s_q;
    assign armed             = (state == ARMED);
    assign state_dbg         = state;
    assign cnt_bus.evt_cnt   = evt_cnt;
    assign cnt_bus.cnt_valid = cnt_valid;
    assign cnt_bus.ovf       = ovf;
endmodule
